pipe_addsub: RTL

// - Parametrised, pipelined carry-segmented adder/subtractor; the next generation of the 8-bit ripple adder.
// - Splits each WIDTH-bit operation into SEG-bit segments. Each segment ripples inside its own pipeline stage.
// - Carries are registered between stages, so throughput is one operation per clock at WIDTH beyond ripple timing.
// - Used in datapaths needing a wide ADD/SUB with a valid/ready stream interface and status flags.

---
 rtl/pipe_addsub.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
// Pipelined carry-segmented adder/subtractor: each SEG-bit slice ripples in its own
// stage, carries are registered between stages, and a valid/ready stream wraps it.

module pipe_addsub_seg #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             c_i,
    input  logic             z_i,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] s_q,
    output logic             c_q,
    output logic             z_q
);
    logic [SEG:0]     sum;
    logic [WIDTH-1:0] s_n;

    // Ripple only slice K; lower slices arrive already summed, upper ones untouched.
    always_comb begin
        sum = {1'b0, a_i[K*SEG +: SEG]} + {1'b0, b_i[K*SEG +: SEG]} + {{SEG{1'b0}}, c_i};
        s_n = s_i;
        s_n[K*SEG +: SEG] = sum[SEG-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else if (adv) begin
            a_q <= a_i;
            b_q <= b_i;
            s_q <= s_n;
            c_q <= sum[SEG];
            z_q <= z_i && (sum[SEG-1:0] == '0);
        end
    end
endmodule

module pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);
    localparam int STAGES = WIDTH / SEG;

    logic [STAGES:0][WIDTH-1:0] a_p, b_p, s_p;
    logic [STAGES:0]            c_p, z_p;
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:1]            vld_q;
    logic                       adv;
    logic                       unused_tail;

    // One global enable: the whole pipe moves or the whole pipe holds, so bubbles keep their slots.
    assign adv       = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = adv;
    assign vld_pipe  = {vld_q, in_valid};

    // Subtraction as a + ~b + ~cin, which makes co read as "no borrow".
    assign a_p[0] = a;
    assign b_p[0] = sub ? ~b : b;
    assign s_p[0] = '0;
    assign c_p[0] = sub ^ cin;
    assign z_p[0] = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_q <= '0;
        else if (adv)
            vld_q <= vld_pipe[STAGES-1:0];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_addsub_seg #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .K     (k)
        ) u_seg (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .a_i   (a_p[k]),
            .b_i   (b_p[k]),
            .s_i   (s_p[k]),
            .c_i   (c_p[k]),
            .z_i   (z_p[k]),
            .a_q   (a_p[k+1]),
            .b_q   (b_p[k+1]),
            .s_q   (s_p[k+1]),
            .c_q   (c_p[k+1]),
            .z_q   (z_p[k+1])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign s         = s_p[STAGES];
    assign co        = c_p[STAGES];
    assign zero      = z_p[STAGES];
    // Operand sign bits ride along to the last stage purely for the overflow flag.
    assign ovf       = (a_p[STAGES][WIDTH-1] == b_p[STAGES][WIDTH-1]) &&
                       (s_p[STAGES][WIDTH-1] != a_p[STAGES][WIDTH-1]);

    assign unused_tail = ^{a_p[STAGES][WIDTH-2:0], b_p[STAGES][WIDTH-2:0]};
endmodule
